ysyx_24110015_axi_arbiter: RTL and testbench

YSYX_24110015_AXI_ARBITER -- requirements
Module: ysyx_24110015_axi_arbiter

---
 rtl/ysyx_24110015_axi_arbiter_if.sv | 41 ++++
 rtl/ysyx_24110015_axi_arbiter.sv | 143 ++++++++++++++
 tb/tb_ysyx_24110015_axi_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// AXI4-lite-style bundle (single-beat write, burst-tolerant read) shared by
// the IFU, the LSU and the downstream slave port of the arbiter.
interface axi_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // Seen from the arbiter: it is the slave of an upstream master.
  modport slave (
    input  araddr, arsize, arvalid, rready,
    input  awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid,
    output awready, wready, bresp, bvalid
  );

  // Seen from the arbiter: it is the master of the downstream slave.
  modport master (
    output araddr, arsize, arvalid, rready,
    output awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master to one-slave AXI arbiter. A registered grant selects IFU read,
// LSU read or LSU write; the granted channels are then wired straight through
// until the transaction's last response, followed by one IDLE cycle.
module ysyx_24110015_axi_arbiter #(
  parameter bit LSU_FIRST = 1'b1
) (
  input logic   clk,
  input logic   rst,
  axi_if.slave  ifu,
  axi_if.slave  lsu,
  axi_if.master out
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

  state_e state_q, state_d;
  logic   addr_done_q, addr_done_d;
  logic   data_done_q, data_done_d;

  // State and handshake-progress registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all three flops update from the same pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      addr_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_done_q <= addr_done_d;
      data_done_q <= data_done_d;
    end
  end

  // Arbitration in IDLE, handshake tracking and end-of-transaction detection.
  always_comb begin
    state_d     = state_q;
    addr_done_d = addr_done_q;
    data_done_d = data_done_q;
    case (state_q)
      IDLE: begin
        if (LSU_FIRST) begin
          if (lsu.awvalid)      state_d = LSU_WR;
          else if (lsu.arvalid) state_d = LSU_RD;
          else if (ifu.arvalid) state_d = IFU_RD;
        end else begin
          if (ifu.arvalid)      state_d = IFU_RD;
          else if (lsu.awvalid) state_d = LSU_WR;
          else if (lsu.arvalid) state_d = LSU_RD;
        end
      end
      IFU_RD, LSU_RD: begin
        if (out.arvalid && out.arready) addr_done_d = 1'b1;
        if (out.rvalid && out.rready && out.rlast) state_d = IDLE;
      end
      LSU_WR: begin
        if (out.awvalid && out.awready) addr_done_d = 1'b1;
        if (out.wvalid && out.wready)   data_done_d = 1'b1;
        if (out.bvalid && out.bready)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flags only live for the duration of one granted transaction.
    if (state_d == IDLE) begin
      addr_done_d = 1'b0;
      data_done_d = 1'b0;
    end
  end

  // Channel routing: granted master wired to out, everything else held at 0.
  always_comb begin
    // NOTE: every output is defaulted first so no state leaves a latch behind.
    out.araddr  = '0;
    out.arsize  = '0;
    out.arvalid = 1'b0;
    out.rready  = 1'b0;
    out.awaddr  = '0;
    out.awsize  = '0;
    out.awvalid = 1'b0;
    out.wdata   = '0;
    out.wstrb   = '0;
    out.wlast   = 1'b0;
    out.wvalid  = 1'b0;
    out.bready  = 1'b0;
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = '0;
    ifu.rlast   = 1'b0;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = '0;
    ifu.bvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = '0;
    lsu.rlast   = 1'b0;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = '0;
    lsu.bvalid  = 1'b0;
    case (state_q)
      IFU_RD: begin
        out.araddr  = ifu.araddr;
        out.arsize  = ifu.arsize;
        out.arvalid = ifu.arvalid && !addr_done_q;
        ifu.arready = out.arready && !addr_done_q;
        out.rready  = ifu.rready;
        ifu.rdata   = out.rdata;
        ifu.rresp   = out.rresp;
        ifu.rlast   = out.rlast;
        ifu.rvalid  = out.rvalid;
      end
      LSU_RD: begin
        out.araddr  = lsu.araddr;
        out.arsize  = lsu.arsize;
        out.arvalid = lsu.arvalid && !addr_done_q;
        lsu.arready = out.arready && !addr_done_q;
        out.rready  = lsu.rready;
        lsu.rdata   = out.rdata;
        lsu.rresp   = out.rresp;
        lsu.rlast   = out.rlast;
        lsu.rvalid  = out.rvalid;
      end
      LSU_WR: begin
        out.awaddr  = lsu.awaddr;
        out.awsize  = lsu.awsize;
        out.awvalid = lsu.awvalid && !addr_done_q;
        lsu.awready = out.awready && !addr_done_q;
        out.wdata   = lsu.wdata;
        out.wstrb   = lsu.wstrb;
        out.wlast   = lsu.wlast;
        out.wvalid  = lsu.wvalid && !data_done_q;
        lsu.wready  = out.wready && !data_done_q;
        out.bready  = lsu.bready;
        lsu.bresp   = out.bresp;
        lsu.bvalid  = out.bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Directed bench for the AXI arbiter: stimulus pushes expected handshakes into
// a queue, a negedge monitor pops and compares every completed handshake.
module tb_ysyx_24110015_axi_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_if ifu_bus ();
  axi_if lsu_bus ();
  axi_if out_bus ();

  ysyx_24110015_axi_arbiter #(.LSU_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus),
    .lsu (lsu_bus),
    .out (out_bus)
  );

  typedef enum logic [2:0] {EV_AR, EV_AW, EV_W, EV_IFU_R, EV_LSU_R, EV_B} ev_e;
  typedef struct {
    ev_e         ev;
    logic [31:0] data;
    logic [7:0]  aux;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  function automatic void push(ev_e ev, logic [31:0] data, logic [7:0] aux);
    exp_q.push_back('{ev, data, aux});
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_got(ev_e ev, logic [31:0] data, logic [7:0] aux);
    exp_t e;
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++;
      $display("FAIL sb_unexpected: got %s data=0x%08h aux=0x%02h, queue empty at %0t",
               ev.name(), data, aux, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.ev !== ev || e.data !== data || e.aux !== aux) begin
        n_mismatched++;
        $display("FAIL sb_%s: got %s data=0x%08h aux=0x%02h expected %s data=0x%08h aux=0x%02h at %0t",
                 e.ev.name(), ev.name(), data, aux, e.ev.name(), e.data, e.aux, $time);
      end
    end
  endtask

  // Monitor: every completed handshake on a DUT-driven valid is one event.
  always @(negedge clk) begin
    if (out_bus.arvalid && out_bus.arready) sb_got(EV_AR, out_bus.araddr, {5'b0, out_bus.arsize});
    if (out_bus.awvalid && out_bus.awready) sb_got(EV_AW, out_bus.awaddr, {5'b0, out_bus.awsize});
    if (out_bus.wvalid && out_bus.wready)
      sb_got(EV_W, out_bus.wdata, {3'b0, out_bus.wlast, out_bus.wstrb});
    if (ifu_bus.rvalid && ifu_bus.rready)
      sb_got(EV_IFU_R, ifu_bus.rdata, {5'b0, ifu_bus.rlast, ifu_bus.rresp});
    if (lsu_bus.rvalid && lsu_bus.rready)
      sb_got(EV_LSU_R, lsu_bus.rdata, {5'b0, lsu_bus.rlast, lsu_bus.rresp});
    if (lsu_bus.bvalid && lsu_bus.bready) sb_got(EV_B, 32'h0, {6'b0, lsu_bus.bresp});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Every DUT-driven control bit and address/data field must be 0 in IDLE.
  task automatic check_idle(string name);
    logic [31:0] ctl;
    logic [31:0] dat;
    ctl = {14'b0,
           out_bus.arvalid, out_bus.awvalid, out_bus.wvalid, out_bus.rready, out_bus.bready,
           ifu_bus.arready, ifu_bus.rvalid, ifu_bus.awready, ifu_bus.wready, ifu_bus.bvalid,
           lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid,
           out_bus.wlast, ifu_bus.rlast, lsu_bus.rlast};
    dat = out_bus.araddr | out_bus.awaddr | out_bus.wdata | {28'b0, out_bus.wstrb}
        | {29'b0, out_bus.arsize} | {29'b0, out_bus.awsize};
    check({name, "_ctl"}, ctl, 32'h0);
    check({name, "_dat"}, dat, 32'h0);
  endtask

  task automatic init_bus();
    ifu_bus.araddr = '0; ifu_bus.arsize = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 1;
    ifu_bus.awaddr = '0; ifu_bus.awsize = '0; ifu_bus.awvalid = 0;
    ifu_bus.wdata = '0; ifu_bus.wstrb = '0; ifu_bus.wlast = 0; ifu_bus.wvalid = 0; ifu_bus.bready = 1;
    lsu_bus.araddr = '0; lsu_bus.arsize = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 1;
    lsu_bus.awaddr = '0; lsu_bus.awsize = '0; lsu_bus.awvalid = 0;
    lsu_bus.wdata = '0; lsu_bus.wstrb = '0; lsu_bus.wlast = 0; lsu_bus.wvalid = 0; lsu_bus.bready = 1;
    out_bus.arready = 0; out_bus.rdata = '0; out_bus.rresp = '0; out_bus.rlast = 0; out_bus.rvalid = 0;
    out_bus.awready = 0; out_bus.wready = 0; out_bus.bresp = '0; out_bus.bvalid = 0;
  endtask

  task automatic r_beat(logic [31:0] data, logic [1:0] resp, logic last);
    out_bus.rvalid = 1; out_bus.rdata = data; out_bus.rresp = resp; out_bus.rlast = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1);
  end

  initial begin
    init_bus();
    rst = 1;
    tick(); tick();
    rst = 0;
    settle();
    check_idle("reset");

    // IFU-only read; IFU keeps arvalid high to exercise the one-outstanding gate.
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h3000_0000; ifu_bus.arsize = 3'd2;
    out_bus.arready = 1;
    push(EV_AR, 32'h3000_0000, 8'h02);
    settle();
    check("ifu_grant_registered", {31'b0, out_bus.arvalid}, 32'h0);
    tick(); settle();
    check("ifu_ar_valid", {31'b0, out_bus.arvalid}, 32'h1);
    check("ifu_ar_addr", out_bus.araddr, 32'h3000_0000);
    tick();
    r_beat(32'h0000_0413, 2'b00, 1);
    push(EV_IFU_R, 32'h0000_0413, 8'h04);
    settle();
    check("ifu_ar_gated", {31'b0, out_bus.arvalid}, 32'h0);
    check("ifu_r_same_cycle", {31'b0, ifu_bus.rvalid}, 32'h1);
    tick();
    ifu_bus.arvalid = 0;
    settle();
    check("ifu_r_dropped_idle", {31'b0, ifu_bus.rvalid}, 32'h0);
    check_idle("ifu_done");
    out_bus.rvalid = 0; out_bus.rlast = 0;
    tick();

    // Collision: LSU read wins, IFU waits through the LSU beat plus IDLE.
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h3000_0004;
    lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h8000_0010; lsu_bus.arsize = 3'd2;
    push(EV_AR, 32'h8000_0010, 8'h02);
    tick(); settle();
    check("coll_lsu_addr", out_bus.araddr, 32'h8000_0010);
    check("coll_ifu_arready0_a", {31'b0, ifu_bus.arready}, 32'h0);
    tick();
    lsu_bus.arvalid = 0;
    r_beat(32'hDEAD_BEEF, 2'b00, 1);
    push(EV_LSU_R, 32'hDEAD_BEEF, 8'h04);
    settle();
    check("coll_ifu_arready0_b", {31'b0, ifu_bus.arready}, 32'h0);
    tick();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    push(EV_AR, 32'h3000_0004, 8'h02);
    settle();
    check_idle("coll_gap");
    tick(); settle();
    check("coll_ifu_addr", out_bus.araddr, 32'h3000_0004);
    tick();
    ifu_bus.arvalid = 0;
    r_beat(32'h0010_0073, 2'b00, 1);
    push(EV_IFU_R, 32'h0010_0073, 8'h04);
    tick();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    tick();

    // LSU write: W handshakes first, AW two cycles later, valids held by master.
    lsu_bus.awvalid = 1; lsu_bus.awaddr = 32'h8000_0100; lsu_bus.awsize = 3'd2;
    lsu_bus.wvalid = 1; lsu_bus.wdata = 32'h0000_AB00; lsu_bus.wstrb = 4'b0010; lsu_bus.wlast = 1;
    out_bus.awready = 0; out_bus.wready = 1; out_bus.arready = 0;
    push(EV_W, 32'h0000_AB00, 8'h12);
    push(EV_AW, 32'h8000_0100, 8'h02);
    tick(); settle();
    check("wr_awvalid_pending", {31'b0, out_bus.awvalid}, 32'h1);
    tick(); settle();
    check("wr_wvalid_gated", {31'b0, out_bus.wvalid}, 32'h0);
    tick();
    out_bus.awready = 1;
    settle();
    check("wr_lsu_awready", {31'b0, lsu_bus.awready}, 32'h1);
    tick();
    out_bus.bvalid = 1; out_bus.bresp = 2'b00;
    push(EV_B, 32'h0, 8'h00);
    settle();
    check("wr_awvalid_gated", {31'b0, out_bus.awvalid}, 32'h0);
    check("wr_lsu_bvalid", {31'b0, lsu_bus.bvalid}, 32'h1);
    tick(); settle();
    check("wr_b_dropped_idle", {31'b0, lsu_bus.bvalid}, 32'h0);
    lsu_bus.awvalid = 0; lsu_bus.wvalid = 0; lsu_bus.wlast = 0;
    out_bus.bvalid = 0; out_bus.awready = 0; out_bus.wready = 0;
    tick();

    // Error passthrough on LSU read.
    out_bus.arready = 1;
    lsu_bus.arvalid = 1; lsu_bus.araddr = 32'hC000_0000; lsu_bus.arsize = 3'd2;
    push(EV_AR, 32'hC000_0000, 8'h02);
    tick(); tick();
    lsu_bus.arvalid = 0;
    r_beat(32'h0000_0000, 2'b11, 1);
    push(EV_LSU_R, 32'h0000_0000, 8'h07);
    settle();
    check("err_rresp", {30'b0, lsu_bus.rresp}, 32'h3);
    tick();
    out_bus.rvalid = 0; out_bus.rlast = 0; out_bus.rresp = 0;
    settle();
    check_idle("err_done");
    tick();

    // Reset after the AR handshake, before R; the late R must be dropped.
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h3000_0008;
    push(EV_AR, 32'h3000_0008, 8'h02);
    tick(); tick();
    ifu_bus.arvalid = 0;
    rst = 1;
    tick();
    rst = 0;
    r_beat(32'h0000_1234, 2'b00, 1);
    settle();
    check_idle("rst_mid");
    tick(); settle();
    check("rst_late_r", {30'b0, ifu_bus.rvalid, lsu_bus.rvalid}, 32'h0);
    out_bus.rvalid = 0; out_bus.rlast = 0;
    tick();

    // 4-beat burst; only the last beat ends the transaction.
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h3000_0100;
    push(EV_AR, 32'h3000_0100, 8'h02);
    tick(); tick();
    ifu_bus.arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      r_beat(32'h0000_00A0 + i, 2'b00, i == 3);
      push(EV_IFU_R, 32'h0000_00A0 + i, (i == 3) ? 8'h04 : 8'h00);
      settle();
      check("burst_rvalid", {31'b0, ifu_bus.rvalid}, 32'h1);
      tick();
    end
    r_beat(32'h0000_00FF, 2'b00, 0);
    settle();
    check("burst_after_last", {31'b0, ifu_bus.rvalid}, 32'h0);
    out_bus.rvalid = 0;
    tick();

    // Withdrawal: request raised and dropped within the IDLE cycle.
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h3000_0010;
    #2;
    ifu_bus.arvalid = 0;
    tick(); settle();
    check("withdraw_no_grant", {31'b0, out_bus.arvalid}, 32'h0);
    tick();

    // Three-way request: write, then LSU read, then IFU read; IFU write inert.
    lsu_bus.awvalid = 1; lsu_bus.awaddr = 32'h8000_0200; lsu_bus.awsize = 3'd2;
    lsu_bus.wvalid = 1; lsu_bus.wdata = 32'hCAFE_F00D; lsu_bus.wstrb = 4'hF; lsu_bus.wlast = 1;
    lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h8000_0300; lsu_bus.arsize = 3'd2;
    ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h3000_0200;
    ifu_bus.awvalid = 1; ifu_bus.wvalid = 1;
    out_bus.awready = 1; out_bus.wready = 1; out_bus.arready = 1;
    push(EV_AW, 32'h8000_0200, 8'h02);
    push(EV_W, 32'hCAFE_F00D, 8'h1F);
    tick(); settle();
    check("prio_wr_first", {30'b0, out_bus.arvalid, out_bus.awvalid}, 32'h1);
    tick();
    lsu_bus.awvalid = 0; lsu_bus.wvalid = 0; lsu_bus.wlast = 0;
    out_bus.bvalid = 1; out_bus.bresp = 2'b10;
    push(EV_B, 32'h0, 8'h02);
    settle();
    check("ifu_wr_inert", {29'b0, ifu_bus.awready, ifu_bus.wready, ifu_bus.bvalid}, 32'h0);
    tick();
    out_bus.bvalid = 0; out_bus.bresp = 0;
    push(EV_AR, 32'h8000_0300, 8'h02);
    settle();
    check_idle("prio_gap");
    tick(); settle();
    check("prio_lsu_rd", out_bus.araddr, 32'h8000_0300);
    tick();
    lsu_bus.arvalid = 0;
    r_beat(32'h55AA_55AA, 2'b00, 1);
    push(EV_LSU_R, 32'h55AA_55AA, 8'h04);
    tick();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    push(EV_AR, 32'h3000_0200, 8'h02);
    tick(); settle();
    check("prio_ifu_rd", out_bus.araddr, 32'h3000_0200);
    tick();
    ifu_bus.arvalid = 0;
    r_beat(32'h1111_2222, 2'b00, 1);
    push(EV_IFU_R, 32'h1111_2222, 8'h04);
    tick();
    out_bus.rvalid = 0; out_bus.rlast = 0;
    ifu_bus.awvalid = 0; ifu_bus.wvalid = 0;
    tick(); tick();

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_compared++;
      n_mismatched++;
      $display("FAIL sb_missing: expected %s data=0x%08h aux=0x%02h never observed",
               e.ev.name(), e.data, e.aux);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
